// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate truth-table self-test: FSM state codes,
// named truth tables for the common two-input gates, and a lookup helper.
package gate_check_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Truth tables; bit index is the input vector {A,B}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    function automatic logic expected_bit(input logic [3:0] tt, input logic [1:0] vec);
        return tt[vec];
    endfunction

endpackage

// File: rtl/gate_vec_sequencer.sv
// Settle-time counter and 2-bit input-vector counter for the gate checker.
// Tells the FSM when the current vector has settled and when it is the last one.
module gate_vec_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_clear,
    input  logic       i_drive,
    input  logic       i_advance,
    output logic [1:0] vec,
    output logic       sample_pulse,
    output logic       last_vec
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    logic [3:0] r_hold;
    logic [1:0] r_vec;
    logic       w_hold_end;

    assign w_hold_end = (r_hold == HOLD_LAST);

    // The hold counter is zeroed on the edge that leaves DRIVE, so it is
    // already 0 when the next vector's DRIVE phase begins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= 4'd0;
            r_vec  <= 2'd0;
        end else if (i_clear) begin
            r_hold <= 4'd0;
            r_vec  <= 2'd0;
        end else if (i_drive) begin
            r_hold <= w_hold_end ? 4'd0 : r_hold + 4'd1;
        end else if (i_advance && (r_vec != 2'd3)) begin
            r_vec  <= r_vec + 2'd1;
        end
    end

    assign vec          = r_vec;
    assign sample_pulse = i_drive && w_hold_end;
    assign last_vec     = (r_vec == 2'd3);

endmodule

// File: rtl/gate_truth_checker.sv
// Stimulus/response self-test around a two-input gate: walks {A,B}=00..11,
// samples the gate output after a settle time and accumulates mismatches.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [3:0] TRUTH       = TT_AND
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       outA,
    output logic       outB,
    input  logic       inY,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] errCount,
    output logic [3:0] failMask,
    output logic [1:0] o_dbg_state
);

    // Handshake: start is a level sampled only while idle (IDLE/DONE); the
    // edge that sees it high is the accepting edge. While busy it is ignored.

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_err_count;
    logic [3:0] r_fail_mask;

    logic       w_accept;
    logic       w_in_drive;
    logic       w_in_sample;
    logic       w_mismatch;
    logic [1:0] w_vec;
    logic       w_sample_pulse;
    logic       w_last_vec;

    assign w_in_drive  = (r_state == DRIVE);
    assign w_in_sample = (r_state == SAMPLE);
    assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch  = w_in_sample && (inY != expected_bit(TRUTH, w_vec));

    gate_vec_sequencer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_accept),
        .i_drive      (w_in_drive),
        .i_advance    (w_in_sample),
        .vec          (w_vec),
        .sample_pulse (w_sample_pulse),
        .last_vec     (w_last_vec)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = DRIVE;
            DRIVE:   if (w_sample_pulse) w_next_state = SAMPLE;
            SAMPLE:  w_next_state = w_last_vec ? DONE : DRIVE;
            DONE:    if (w_accept) w_next_state = DRIVE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_err_count <= 3'd0;
            r_fail_mask <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_err_count <= 3'd0;
                r_fail_mask <= 4'd0;
            end else if (w_mismatch) begin
                r_err_count        <= r_err_count + 3'd1;
                r_fail_mask[w_vec] <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only; inY never reaches an output combinationally.
    assign busy        = w_in_drive || w_in_sample;
    assign done        = (r_state == DONE);
    assign pass        = done && (r_err_count == 3'd0);
    assign outA        = busy && w_vec[1];
    assign outB        = busy && w_vec[0];
    assign errCount    = r_err_count;
    assign failMask    = r_fail_mask;
    assign o_dbg_state = r_state;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset_n) !(busy && done));
    a_err_bound:      assert property (@(posedge clk) disable iff (!reset_n) errCount <= 3'd4);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (AND/hold 2, NAND/hold 1) driving
// table-defined gates, checked every cycle against a run-position model.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  localparam int         HOLD0 = 2;
  localparam int         HOLD1 = 1;
  localparam logic [3:0] TT0   = TT_AND;
  localparam logic [3:0] TT1   = TT_NAND;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // stimulus and DUT outputs
  logic       start_v[2];
  logic [3:0] gate_tbl[2];
  logic       outa_v[2], outb_v[2], busy_v[2], done_v[2], pass_v[2];
  logic [2:0] err_v[2];
  logic [3:0] mask_v[2];
  logic [1:0] dbg_v[2];
  logic       y0, y1;

  // the gate under test is whatever truth table gate_tbl holds
  assign y0 = gate_tbl[0][{outa_v[0], outb_v[0]}];
  assign y1 = gate_tbl[1][{outa_v[1], outb_v[1]}];

  gate_truth_checker #(.HOLD_CYCLES(HOLD0), .TRUTH(TT0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .outA(outa_v[0]), .outB(outb_v[0]),
    .inY(y0), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .errCount(err_v[0]),
    .failMask(mask_v[0]), .o_dbg_state(dbg_v[0])
  );

  gate_truth_checker #(.HOLD_CYCLES(HOLD1), .TRUTH(TT1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .outA(outa_v[1]), .outB(outb_v[1]),
    .inY(y1), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .errCount(err_v[1]),
    .failMask(mask_v[1]), .o_dbg_state(dbg_v[1])
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // behavioural model: a run is a count of edges since the accepting edge
  bit         m_act[2];
  int         m_n[2];
  logic [3:0] m_fail[2];

  function automatic int period(input int k);
    return ((k == 0) ? HOLD0 : HOLD1) + 1;
  endfunction

  function automatic logic [3:0] tt(input int k);
    return (k == 0) ? TT0 : TT1;
  endfunction

  function automatic bit m_busy(input int k);
    return m_act[k] && (m_n[k] < 4 * period(k));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k]  <= 1'b0;
        m_n[k]    <= 0;
        m_fail[k] <= 4'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy(k) && start_v[k]) begin
          m_act[k]  <= 1'b1;
          m_n[k]    <= 0;
          m_fail[k] <= gate_tbl[k] ^ tt(k);
        end else if (m_busy(k)) begin
          m_n[k] <= m_n[k] + 1;
        end
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int         per;
        int         v;
        bit         eb;
        bit         ed;
        logic [3:0] em;
        int         ec;
        per = period(k);
        eb  = m_busy(k);
        ed  = m_act[k] && !eb;
        v   = eb ? (m_n[k] / per) : 0;
        em  = 4'd0;
        if (m_act[k])
          for (int j = 0; j < 4; j++)
            if ((j + 1) * per <= m_n[k]) em[j] = m_fail[k][j];
        ec = $countones(em);
        chk("busy", k, busy_v[k], eb);
        chk("done", k, done_v[k], ed);
        chk("pass", k, pass_v[k], ed && (ec == 0));
        chk("errCount", k, err_v[k], ec);
        chk("failMask", k, mask_v[k], em);
        chk("outA", k, outa_v[k], eb && ((v >> 1) & 1));
        chk("outB", k, outb_v[k], eb && (v & 1));
      end
    end
  end

  // driver: one run on dut k with literal end-of-run expectations.
  // Called #1 after an edge while dut k is idle or done.
  task automatic run_lit(input int k, input logic [3:0] g, input logic [3:0] exp_mask,
                         input int exp_err, input int exp_edges);
    gate_tbl[k] = g;
    start_v[k]  = 1'b1;
    @(posedge clk); #1;
    start_v[k]  = 1'b0;
    chk("lit_busy_after_accept", k, busy_v[k], 1);
    chk("lit_done_cleared", k, done_v[k], 0);
    chk("lit_mask_cleared", k, mask_v[k], 0);
    chk("lit_err_cleared", k, err_v[k], 0);
    chk("lit_ab_first", k, {outa_v[k], outb_v[k]}, 2'b00);
    repeat (exp_edges - 1) @(posedge clk);
    #1;
    chk("lit_done_early", k, done_v[k], 0);
    @(posedge clk); #1;
    chk("lit_done", k, done_v[k], 1);
    chk("lit_busy_end", k, busy_v[k], 0);
    chk("lit_mask", k, mask_v[k], exp_mask);
    chk("lit_err", k, err_v[k], exp_err);
    chk("lit_pass", k, pass_v[k], exp_err == 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    start_v[0]  = 1'b0;
    start_v[1]  = 1'b0;
    gate_tbl[0] = 4'b1000;
    gate_tbl[1] = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, busy_v[k], 0);
      chk("rst_done", k, done_v[k], 0);
      chk("rst_pass", k, pass_v[k], 0);
      chk("rst_err", k, err_v[k], 0);
      chk("rst_mask", k, mask_v[k], 0);
      chk("rst_ab", k, {outa_v[k], outb_v[k]}, 2'b00);
      chk("rst_state", k, dbg_v[k], 0);
    end

    // AND gate, inY stuck at 1, OR gate, all against the AND table
    run_lit(0, 4'b1000, 4'b0000, 0, 12);
    run_lit(0, 4'b1111, 4'b0111, 3, 12);
    run_lit(0, 4'b1110, 4'b0110, 2, 12);

    // start re-pulsed at edges 3 and 7 of a run is ignored
    gate_tbl[0] = 4'b1111;
    start_v[0]  = 1'b1;
    @(posedge clk); #1;
    start_v[0]  = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      start_v[0] = (e == 2) || (e == 6);
      if (e == 11) chk("ign_done_early", 0, done_v[0], 0);
    end
    chk("ign_done", 0, done_v[0], 1);
    chk("ign_mask", 0, mask_v[0], 4'b0111);
    chk("ign_err", 0, err_v[0], 3);
    // start in DONE clears results and runs again
    run_lit(0, 4'b1000, 4'b0000, 0, 12);

    // asynchronous reset at edge 6 of a run
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 0, busy_v[0], 0);
    chk("arst_done", 0, done_v[0], 0);
    chk("arst_ab", 0, {outa_v[0], outb_v[0]}, 2'b00);
    chk("arst_err", 0, err_v[0], 0);
    chk("arst_mask", 0, mask_v[0], 0);
    chk("arst_state", 0, dbg_v[0], 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("arst_no_done", 0, done_v[0], 0);
    chk("arst_idle", 0, busy_v[0], 0);

    // NAND instance, hold 1: vector sequence and completion at edge 8
    gate_tbl[1] = 4'b0111;
    start_v[1]  = 1'b1;
    @(posedge clk); #1;
    start_v[1]  = 1'b0;
    for (int e = 0; e < 8; e++) begin
      chk("nand_ab_seq", 1, {outa_v[1], outb_v[1]}, e / 2);
      if (e == 7) chk("nand_done_early", 1, done_v[1], 0);
      @(posedge clk); #1;
    end
    chk("nand_done", 1, done_v[1], 1);
    chk("nand_pass", 1, pass_v[1], 1);
    chk("nand_err", 1, err_v[1], 0);

    // randomized gates and start patterns on both instances
    for (int it = 0; it < 600; it++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy(k) && ($urandom_range(0, 3) == 0))
          gate_tbl[k] = 4'($urandom_range(0, 15));
        start_v[k] = ($urandom_range(0, 4) == 0);
      end
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_idle0", 0, busy_v[0], 0);
    chk("drain_idle1", 1, busy_v[1], 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
